sram_req_arbiter: RTL

Shares one SRAM-like memory port between the fetch stage (inst requester) and the MEM stage (data requester), in front of the AXI bridge. Each cycle it picks one pending request, forwards it downstream with no added latency, and records its owner in an in-order outstanding queue. Each downstream `data_ok`/`rdata` is steered back to the owner at the queue head. The arbiter never reorders responses and never exceeds `DEPTH` outstanding transactions.

---
 rtl/sram_req_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sram_req_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_req_arbiter : shares one SRAM-like port between inst and data requesters
// with an in-order owner queue; SRAM_ARB_RR_EN selects round-robin grant.
// Revision: 1.0
// ---------------------------------------------------------------------------
module sram_req_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic        resp_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] ids_q, ids_d;
  logic             lock_valid_q, lock_valid_d;
  logic             lock_id_q, lock_id_d;
  logic             resp_err_q, resp_err_d;

  logic full, empty;
  logic pick_id, grant_id, granted_req;
  logic push, pop, head_id;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

`ifdef SRAM_ARB_RR_EN
  logic last_q, last_d;

  always_comb begin
    pick_id = ID_DATA;
    if (inst_req && data_req) begin
      pick_id = ~last_q;
    end else if (inst_req) begin
      pick_id = ID_INST;
    end
  end

  always_comb begin
    last_d = last_q;
    if (push) begin
      last_d = grant_id;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q <= ID_DATA;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Data wins ties and is the idle default so reset exposes data fields.
  always_comb begin
    pick_id = ID_DATA;
    if (!data_req && inst_req) begin
      pick_id = ID_INST;
    end
  end
`endif

  assign grant_id    = lock_valid_q ? lock_id_q : pick_id;
  assign granted_req = (grant_id == ID_DATA) ? data_req : inst_req;

  always_comb begin
    mem_req   = granted_req & ~full;
    mem_wr    = inst_wr;
    mem_size  = inst_size;
    mem_wstrb = inst_wstrb;
    mem_addr  = inst_addr;
    mem_wdata = inst_wdata;
    if (grant_id == ID_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  assign push         = mem_req & mem_addr_ok;
  assign inst_addr_ok = push & (grant_id == ID_INST);
  assign data_addr_ok = push & (grant_id == ID_DATA);

  // Head is read from registered state, so a same-cycle push never aliases it.
  assign head_id      = ids_q[rptr_q];
  assign pop          = mem_data_ok & ~empty;
  assign inst_data_ok = pop & (head_id == ID_INST);
  assign data_data_ok = pop & (head_id == ID_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign resp_err     = resp_err_q;

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    ids_d        = ids_q;
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
    resp_err_d   = resp_err_q | (mem_data_ok & empty);

    if (push) begin
      ids_d[wptr_q] = grant_id;
      wptr_d        = wptr_q + PW'(1);
      lock_valid_d  = 1'b0;
    end else if (mem_req) begin
      lock_valid_d = 1'b1;
      lock_id_d    = grant_id;
    end

    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      ids_q        <= '0;
      lock_valid_q <= 1'b0;
      lock_id_q    <= ID_DATA;
      resp_err_q   <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      ids_q        <= ids_d;
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule
`default_nettype wire
